// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) multiply-by-constant functions, state column indexing
// and the FSM encoding used by the iterative (Inv)MixColumns unit.
package aes_pkg;

    localparam logic [7:0]  AES_POLY = 8'h1b;
    localparam int unsigned STATE_W  = 128;
    localparam int unsigned COL_W    = 32;
    localparam int unsigned NUM_COLS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_e;

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul2(input logic [7:0] a);
        return gf_xtime(a);
    endfunction

    function automatic logic [7:0] gf_mul3(input logic [7:0] a);
        return gf_xtime(a) ^ a;
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] a);
        logic [7:0] x2, x4, x8;
        x2 = gf_xtime(a);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return x8 ^ a;
    endfunction

    function automatic logic [7:0] gf_mulb(input logic [7:0] a);
        logic [7:0] x2, x4, x8;
        x2 = gf_xtime(a);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return x8 ^ x2 ^ a;
    endfunction

    function automatic logic [7:0] gf_muld(input logic [7:0] a);
        logic [7:0] x2, x4, x8;
        x2 = gf_xtime(a);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return x8 ^ x4 ^ a;
    endfunction

    function automatic logic [7:0] gf_mule(input logic [7:0] a);
        logic [7:0] x2, x4, x8;
        x2 = gf_xtime(a);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    // MSB index of column c in the 128-bit state; column 0 sits in the top bits.
    function automatic logic [6:0] col_msb(input logic [1:0] c);
        return 7'(STATE_W - 1 - COL_W * int'(c));
    endfunction

endpackage

// File: rtl/inv_mix_single_column.sv
// One AES column through InvMixColumns (or forward MixColumns when
// AES_MIXCOL_FWD_MODE_EN is defined and fwd_mode=1). Purely combinational.
module inv_mix_single_column
    import aes_pkg::*;
(
`ifdef AES_MIXCOL_FWD_MODE_EN
    input  logic              fwd_mode,
`endif
    input  logic [COL_W-1:0]  col_in,
    output logic [COL_W-1:0]  col_out_c
);

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] r0, r1, r2, r3;

    assign a0 = col_in[31:24];
    assign a1 = col_in[23:16];
    assign a2 = col_in[15:8];
    assign a3 = col_in[7:0];

    always_comb begin
        r0 = gf_mule(a0) ^ gf_mulb(a1) ^ gf_muld(a2) ^ gf_mul9(a3);
        r1 = gf_mul9(a0) ^ gf_mule(a1) ^ gf_mulb(a2) ^ gf_muld(a3);
        r2 = gf_muld(a0) ^ gf_mul9(a1) ^ gf_mule(a2) ^ gf_mulb(a3);
        r3 = gf_mulb(a0) ^ gf_muld(a1) ^ gf_mul9(a2) ^ gf_mule(a3);
`ifdef AES_MIXCOL_FWD_MODE_EN
        if (fwd_mode) begin
            r0 = gf_mul2(a0) ^ gf_mul3(a1) ^ a2          ^ a3;
            r1 = a0          ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3;
            r2 = a0          ^ a1          ^ gf_mul2(a2) ^ gf_mul3(a3);
            r3 = gf_mul3(a0) ^ a1          ^ a2          ^ gf_mul2(a3);
        end
`endif
    end

    assign col_out_c = {r0, r1, r2, r3};

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns: COLS_PER_CYCLE columns per clock, transformed in place,
// valid/ready on both sides. Optional macro AES_MIXCOL_FWD_MODE_EN adds a fwd_mode port.
module inv_mix_columns_seq
    import aes_pkg::*;
#(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
`ifdef AES_MIXCOL_FWD_MODE_EN
    input  logic                fwd_mode,
`endif
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [STATE_W-1:0]  state_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [STATE_W-1:0]  state_out
);

    localparam int unsigned LAT      = NUM_COLS / COLS_PER_CYCLE;
    localparam logic [1:0]  COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0]  LAST_COL = 2'((LAT - 1) * COLS_PER_CYCLE);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
        $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    fsm_state_e          state_q, state_d;
    logic [1:0]          col_q, col_d;
    logic [STATE_W-1:0]  work_q, work_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                accept;
`ifdef AES_MIXCOL_FWD_MODE_EN
    logic                fwd_q, fwd_d;
`endif

    logic [COL_W-1:0]    col_src [COLS_PER_CYCLE];
    logic [COL_W-1:0]    col_res [COLS_PER_CYCLE];

    assign accept = (state_q == ST_IDLE) && in_valid && in_ready_q;

    // Column group currently being worked on: col_q .. col_q+COLS_PER_CYCLE-1.
    for (genvar k = 0; k < int'(COLS_PER_CYCLE); k++) begin : g_col
        assign col_src[k] = work_q[col_msb(col_q + 2'(k)) -: COL_W];

        inv_mix_single_column u_col (
`ifdef AES_MIXCOL_FWD_MODE_EN
            .fwd_mode  (fwd_q),
`endif
            .col_in    (col_src[k]),
            .col_out_c (col_res[k])
        );
    end

    // State register and datapath flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            col_q       <= 2'd0;
            work_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef AES_MIXCOL_FWD_MODE_EN
            fwd_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            work_q      <= work_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef AES_MIXCOL_FWD_MODE_EN
            fwd_q       <= fwd_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)              state_d = ST_BUSY;
            ST_BUSY: if (col_q == LAST_COL)   state_d = ST_DONE;
            ST_DONE: if (out_ready)           state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; handshake flags follow the next state.
    always_comb begin
        col_d       = col_q;
        work_d      = work_q;
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
`ifdef AES_MIXCOL_FWD_MODE_EN
        fwd_d       = fwd_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    work_d = state_in;
                    col_d  = 2'd0;
`ifdef AES_MIXCOL_FWD_MODE_EN
                    fwd_d  = fwd_mode;
`endif
                end
            end
            ST_BUSY: begin
                for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
                    work_d[col_msb(col_q + 2'(k)) -: COL_W] = col_res[k];
                end
                col_d = col_q + COL_STEP;
            end
            default: ;
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign state_out = work_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed bench for inv_mix_columns_seq (COLS_PER_CYCLE = 1, 2, 4 instances).
module tb_inv_mix_columns_seq;

    localparam logic [127:0] V1   = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    localparam logic [127:0] E1   = 128'hdb135345_f20a225c_01010101_2d26314c;
    localparam logic [127:0] V2   = 128'h01000000_00000000_00000000_00000001;
    localparam logic [127:0] E2   = 128'h0e090d0b_00000000_00000000_090d0b0e;
    localparam logic [127:0] V3   = 128'h00000000_80000000_00000000_00000000;
    localparam logic [127:0] E3   = 128'h00000000_41ecdaf7_00000000_00000000;
    localparam logic [127:0] C6   = 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6;
    localparam logic [127:0] ONES = 128'h01010101_01010101_01010101_01010101;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [127:0] state_in, state_out;
    logic         in_valid_v;
    logic         in_ready2, out_valid2, in_ready4, out_valid4;
    logic [127:0] state_out2, state_out4;
`ifdef AES_MIXCOL_FWD_MODE_EN
    logic         fwd_mode;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) dut (
`ifdef AES_MIXCOL_FWD_MODE_EN
        .fwd_mode  (fwd_mode),
`endif
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out)
    );

    inv_mix_columns_seq #(.COLS_PER_CYCLE(2)) dut2 (
`ifdef AES_MIXCOL_FWD_MODE_EN
        .fwd_mode  (1'b0),
`endif
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_v),
        .in_ready  (in_ready2),
        .state_in  (state_in),
        .out_valid (out_valid2),
        .out_ready (1'b1),
        .state_out (state_out2)
    );

    inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) dut4 (
`ifdef AES_MIXCOL_FWD_MODE_EN
        .fwd_mode  (1'b0),
`endif
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_v),
        .in_ready  (in_ready4),
        .state_in  (state_in),
        .out_valid (out_valid4),
        .out_ready (1'b1),
        .state_out (state_out4)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One block through the main instance with out_ready=1; returns result and latency.
    task automatic xfer(input logic [127:0] din, output logic [127:0] dout, output int lat);
        state_in = din;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        dout = state_out;
        tick();
        chk("handshake_out_valid_low", 128'(out_valid), 128'(1'b0));
        chk("handshake_in_ready_high", 128'(in_ready), 128'(1'b1));
    endtask

    task automatic run_block(input string tag, input logic [127:0] din, input logic [127:0] exp);
        logic [127:0] res;
        int           lat;
        xfer(din, res, lat);
        chk({tag, "_latency"}, 128'(lat), 128'(4));
        chk({tag, "_result"}, res, exp);
    endtask

    initial begin
        logic [127:0] r, f, back;
        int           lat;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_valid_v = 1'b0;
        out_ready  = 1'b1;
        state_in   = '0;
`ifdef AES_MIXCOL_FWD_MODE_EN
        fwd_mode   = 1'b0;
`endif
        #12;
        chk("rst_in_ready", 128'(in_ready), 128'(1'b0));
        chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("rst_state_out", state_out, 128'h0);
        chk("rst_state_out4", state_out4, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_before_first_clk", 128'(in_ready), 128'(1'b0));
        tick();
        chk("in_ready_after_release", 128'(in_ready), 128'(1'b1));

        // Known vector on all three widths at once.
        state_in   = V1;
        in_valid   = 1'b1;
        in_valid_v = 1'b1;
        tick();
        in_valid   = 1'b0;
        in_valid_v = 1'b0;
        chk("v1_in_ready_busy", 128'(in_ready), 128'(1'b0));
        chk("v1_cpc4_not_yet", 128'(out_valid4), 128'(1'b0));
        tick();
        chk("v1_cpc4_valid", 128'(out_valid4), 128'(1'b1));
        chk("v1_cpc4_result", state_out4, E1);
        chk("v1_cpc2_not_yet", 128'(out_valid2), 128'(1'b0));
        chk("v1_t1_not_yet", 128'(out_valid), 128'(1'b0));
        tick();
        chk("v1_cpc2_valid", 128'(out_valid2), 128'(1'b1));
        chk("v1_cpc2_result", state_out2, E1);
        chk("v1_t2_not_yet", 128'(out_valid), 128'(1'b0));
        tick();
        chk("v1_t3_not_yet", 128'(out_valid), 128'(1'b0));
        tick();
        chk("v1_valid", 128'(out_valid), 128'(1'b1));
        chk("v1_result", state_out, E1);
        tick();
        chk("v1_out_valid_drop", 128'(out_valid), 128'(1'b0));
        chk("v1_in_ready_back", 128'(in_ready), 128'(1'b1));

        run_block("single_bytes", V2, E2);
        run_block("xtime_reduce", V3, E3);
        run_block("all_c6", C6, C6);

        // Busy-time input is ignored; then back-pressure for 10 cycles.
        out_ready = 1'b0;
        state_in  = V1;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        tick();
        state_in  = C6;
        in_valid  = 1'b1;
        chk("busy_in_ready", 128'(in_ready), 128'(1'b0));
        tick();
        in_valid  = 1'b0;
        tick();
        tick();
        chk("bp_valid", 128'(out_valid), 128'(1'b1));
        chk("bp_result", state_out, E1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold_valid", 128'(out_valid), 128'(1'b1));
            chk("bp_hold_data", state_out, E1);
            chk("bp_hold_in_ready", 128'(in_ready), 128'(1'b0));
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release_valid", 128'(out_valid), 128'(1'b0));
        chk("bp_release_in_ready", 128'(in_ready), 128'(1'b1));

        // Reset in the middle of BUSY (col=2).
        state_in = V1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("midrst_state_out", state_out, 128'h0);
        chk("midrst_in_ready", 128'(in_ready), 128'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("midrst_ready_again", 128'(in_ready), 128'(1'b1));
        run_block("after_rst_ones", ONES, ONES);

`ifdef AES_MIXCOL_FWD_MODE_EN
        fwd_mode = 1'b1;
        run_block("fwd_vector", E1, V1);
        for (int i = 0; i < 3; i++) begin
            r = {$urandom(), $urandom(), $urandom(), $urandom()};
            fwd_mode = 1'b1;
            xfer(r, f, lat);
            fwd_mode = 1'b0;
            xfer(f, back, lat);
            chk("round_trip", back, r);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
